// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the cpu_sequencer control FSM:
// opcodes, FSM states, memory address sources and the strobe bundle.
package cpu_sequencer_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOV  = 8'h01;
    localparam logic [7:0] OP_LDI  = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h10;
    localparam logic [7:0] OP_SUB  = 8'h11;
    localparam logic [7:0] OP_AND  = 8'h12;
    localparam logic [7:0] OP_OR   = 8'h13;
    localparam logic [7:0] OP_XOR  = 8'h14;
    localparam logic [7:0] OP_CMP  = 8'h18;
    localparam logic [7:0] OP_JMP  = 8'h20;
    localparam logic [7:0] OP_CALL = 8'h21;
    localparam logic [7:0] OP_RET  = 8'h22;
    localparam logic [7:0] OP_LDX  = 8'h30;
    localparam logic [7:0] OP_STX  = 8'h31;
    localparam logic [7:0] OP_PUSH = 8'h32;
    localparam logic [7:0] OP_POP  = 8'h33;
    localparam logic [7:0] OP_HLT  = 8'hFF;

    localparam logic [1:0] ASEL_PC  = 2'd0;
    localparam logic [1:0] ASEL_REG = 2'd1;
    localparam logic [1:0] ASEL_SP  = 2'd2;

    typedef enum logic [2:0] {
        SEQ_FETCH,
        SEQ_DECODE,
        SEQ_IMM,
        SEQ_EXEC,
        SEQ_MEM,
        SEQ_HALT
    } seq_state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] mem_asel;
        logic       ir_we;
        logic       imm_we;
        logic       reg_we;
        logic       flags_we;
        logic       pc_inc;
        logic       pc_load;
        logic       sp_inc;
        logic       sp_dec;
    } seq_ctrl_t;

    function automatic logic is_alu(input logic [7:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter for cpu_sequencer.
// Flags a timeout on the TIMEOUT-th consecutive unacknowledged cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic waiting_i,
    output logic timeout_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 1) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count_q, count_d;

    // Count consecutive waiting cycles; any ack or idle cycle restarts it.
    always_comb begin
        count_d = '0;
        if (waiting_i) count_d = count_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    generate
        if (TIMEOUT > 0) begin : g_to
            assign timeout_o = waiting_i && (count_q == LAST);
        end else begin : g_no_to
            assign timeout_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 8-bit core; owns the memory port.
// Optional SEQ_SINGLE_STEP_EN adds a step input gating each fetch.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [7:0] opcode,
    input  logic       cond_true,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_asel,
    output logic       ir_we,
    output logic       imm_we,
    output logic       reg_we,
    output logic       flags_we,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       sp_inc,
    output logic       sp_dec,
    output logic       halted,
    output logic       fault
);

    seq_state_e state_q, state_d;
    logic       fault_q, fault_d;
    logic       fetch_go;
    logic       req_c;
    logic       timeout;
    seq_ctrl_t  ctrl_c, ctrl;

`ifdef SEQ_SINGLE_STEP_EN
    logic go_q, go_d;

    // Arm one fetch per sampled step; disarm once that fetch is acked.
    always_comb begin
        go_d = 1'b0;
        if (state_q == SEQ_FETCH) go_d = go_q ? !mem_ack : step;
    end

    // Step arm register.
    always_ff @(posedge clk) begin
        if (rst) go_q <= 1'b0;
        else     go_q <= go_d;
    end

    assign fetch_go = go_q;
`else
    assign fetch_go = 1'b1;
`endif

    // Request depends on state only, so the timer sees it without a loop.
    always_comb begin
        req_c = 1'b0;
        case (state_q)
            SEQ_FETCH:        req_c = fetch_go;
            SEQ_IMM, SEQ_MEM: req_c = 1'b1;
            default:          req_c = 1'b0;
        endcase
    end

    mem_wait_timer #(
        .TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .waiting_i(req_c & ~mem_ack),
        .timeout_o(timeout)
    );

    // State and sticky fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    // Next state and strobe decode per state and opcode.
    always_comb begin
        state_d        = state_q;
        fault_d        = fault_q;
        ctrl_c         = '0;
        ctrl_c.mem_req = req_c;
        unique case (state_q)
            SEQ_FETCH: begin
                if (fetch_go && mem_ack) begin
                    ctrl_c.ir_we  = 1'b1;
                    ctrl_c.pc_inc = 1'b1;
                    state_d       = SEQ_DECODE;
                end
            end
            SEQ_DECODE: begin
                state_d = SEQ_FETCH;
                if (opcode inside {OP_LDI, OP_JMP, OP_CALL}) begin
                    state_d = SEQ_IMM;
                end else if (opcode == OP_HLT) begin
                    state_d = SEQ_HALT;
                end else if (is_alu(opcode) ||
                             opcode inside {OP_MOV, OP_CMP, OP_RET, OP_LDX,
                                            OP_STX, OP_PUSH, OP_POP}) begin
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_IMM: begin
                if (mem_ack) begin
                    ctrl_c.imm_we = 1'b1;
                    ctrl_c.pc_inc = 1'b1;
                    state_d       = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                state_d = SEQ_FETCH;
                case (opcode)
                    OP_MOV, OP_LDI: ctrl_c.reg_we = 1'b1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        ctrl_c.reg_we   = 1'b1;
                        ctrl_c.flags_we = 1'b1;
                    end
                    OP_CMP: ctrl_c.flags_we = 1'b1;
                    OP_JMP: ctrl_c.pc_load = cond_true;
                    OP_LDX, OP_STX, OP_POP, OP_RET: state_d = SEQ_MEM;
                    OP_PUSH, OP_CALL: begin
                        ctrl_c.sp_dec = 1'b1;
                        state_d       = SEQ_MEM;
                    end
                    default: ;
                endcase
            end
            SEQ_MEM: begin
                case (opcode)
                    OP_LDX: ctrl_c.mem_asel = ASEL_REG;
                    OP_STX: begin
                        ctrl_c.mem_we   = 1'b1;
                        ctrl_c.mem_asel = ASEL_REG;
                    end
                    OP_PUSH, OP_CALL: begin
                        ctrl_c.mem_we   = 1'b1;
                        ctrl_c.mem_asel = ASEL_SP;
                    end
                    OP_POP, OP_RET: ctrl_c.mem_asel = ASEL_SP;
                    default: ;
                endcase
                if (mem_ack) begin
                    state_d = SEQ_FETCH;
                    case (opcode)
                        OP_LDX: ctrl_c.reg_we = 1'b1;
                        OP_POP: begin
                            ctrl_c.reg_we = 1'b1;
                            ctrl_c.sp_inc = 1'b1;
                        end
                        OP_RET: begin
                            ctrl_c.pc_load = 1'b1;
                            ctrl_c.sp_inc  = 1'b1;
                        end
                        OP_CALL: ctrl_c.pc_load = 1'b1;
                        default: ;
                    endcase
                end
            end
            SEQ_HALT: ;
            default: state_d = SEQ_FETCH;
        endcase
        if (timeout) begin
            state_d = SEQ_HALT;
            fault_d = 1'b1;
        end
    end

    assign ctrl     = rst ? '0 : ctrl_c;
    assign mem_req  = ctrl.mem_req;
    assign mem_we   = ctrl.mem_we;
    assign mem_asel = ctrl.mem_asel;
    assign ir_we    = ctrl.ir_we;
    assign imm_we   = ctrl.imm_we;
    assign reg_we   = ctrl.reg_we;
    assign flags_we = ctrl.flags_we;
    assign pc_inc   = ctrl.pc_inc;
    assign pc_load  = ctrl.pc_load;
    assign sp_inc   = ctrl.sp_inc;
    assign sp_dec   = ctrl.sp_dec;
    assign halted   = !rst && (state_q == SEQ_HALT);
    assign fault    = !rst && fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-instruction step-list model,
// directed scenarios with literal pins, then randomized memory timing.
`timescale 1ns/1ps
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam int TO = 16;

    localparam int B_FAULT = 0;
    localparam int B_HALT  = 1;
    localparam int B_SPDEC = 2;
    localparam int B_SPINC = 3;
    localparam int B_PCLD  = 4;
    localparam int B_PCINC = 5;
    localparam int B_FLG   = 6;
    localparam int B_REG   = 7;
    localparam int B_IMM   = 8;
    localparam int B_IR    = 9;
    localparam int B_ASEL  = 10;
    localparam int B_WE    = 12;
    localparam int B_REQ   = 13;

    localparam logic [13:0] S_NONE  = 14'd0;
    localparam logic [13:0] S_SPDEC = 14'd1 << B_SPDEC;
    localparam logic [13:0] S_SPINC = 14'd1 << B_SPINC;
    localparam logic [13:0] S_PCLD  = 14'd1 << B_PCLD;
    localparam logic [13:0] S_PCINC = 14'd1 << B_PCINC;
    localparam logic [13:0] S_FLG   = 14'd1 << B_FLG;
    localparam logic [13:0] S_REG   = 14'd1 << B_REG;
    localparam logic [13:0] S_IMM   = 14'd1 << B_IMM;
    localparam logic [13:0] S_IR    = 14'd1 << B_IR;

    logic       clk, rst, cond_true, mem_ack;
    logic [7:0] opcode;
    logic       mem_req, mem_we, ir_we, imm_we, reg_we, flags_we;
    logic       pc_inc, pc_load, sp_inc, sp_dec, halted, fault;
    logic [1:0] mem_asel;

    cpu_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .cond_true(cond_true),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_asel(mem_asel), .ir_we(ir_we), .imm_we(imm_we),
        .reg_we(reg_we), .flags_we(flags_we), .pc_inc(pc_inc),
        .pc_load(pc_load), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit          mem;
        bit          we;
        bit [1:0]    asel;
        logic [13:0] fx;
        bit          jmp;
        bit          fetch;
        bit          hlt;
    } step_t;

    int          n_chk = 0;
    int          n_fail = 0;
    step_t       q[$];
    logic [7:0]  prog[$];
    bit          m_halt, m_fault, pend_v;
    int          m_wait;
    logic [7:0]  pend_op;
    int          cyc;
    logic [13:0] lg[0:63];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic logic [13:0] obs_vec();
        return {mem_req, mem_we, mem_asel, ir_we, imm_we, reg_we, flags_we,
                pc_inc, pc_load, sp_inc, sp_dec, halted, fault};
    endfunction

    function automatic step_t fx_step(input logic [13:0] fx, input bit jmp);
        step_t s = '0;
        s.fx  = fx;
        s.jmp = jmp;
        return s;
    endfunction

    function automatic step_t mem_step(input bit we, input logic [1:0] as,
                                       input logic [13:0] fx);
        step_t s = '0;
        s.mem  = 1'b1;
        s.we   = we;
        s.asel = as;
        s.fx   = fx;
        return s;
    endfunction

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 17))
            0:  return OP_NOP;
            1:  return OP_MOV;
            2:  return OP_LDI;
            3:  return OP_ADD;
            4:  return OP_SUB;
            5:  return OP_AND;
            6:  return OP_OR;
            7:  return OP_XOR;
            8:  return OP_CMP;
            9:  return OP_JMP;
            10: return OP_CALL;
            11: return OP_RET;
            12: return OP_LDX;
            13: return OP_STX;
            14: return OP_PUSH;
            15: return OP_POP;
            16: return 8'h7E;
            default: return ($urandom_range(0, 9) == 0) ? OP_HLT : OP_POP;
        endcase
    endfunction

    // Steps an instruction takes after its fetch completes.
    task automatic expand(input logic [7:0] op);
        step_t imm = mem_step(1'b0, ASEL_PC, S_IMM | S_PCINC);
        step_t h = '0;
        h.hlt = 1'b1;
        q.push_back(fx_step(S_NONE, 1'b0));
        case (op)
            OP_MOV: q.push_back(fx_step(S_REG, 1'b0));
            OP_LDI: begin
                q.push_back(imm);
                q.push_back(fx_step(S_REG, 1'b0));
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                q.push_back(fx_step(S_REG | S_FLG, 1'b0));
            OP_CMP: q.push_back(fx_step(S_FLG, 1'b0));
            OP_JMP: begin
                q.push_back(imm);
                q.push_back(fx_step(S_NONE, 1'b1));
            end
            OP_CALL: begin
                q.push_back(imm);
                q.push_back(fx_step(S_SPDEC, 1'b0));
                q.push_back(mem_step(1'b1, ASEL_SP, S_PCLD));
            end
            OP_RET: begin
                q.push_back(fx_step(S_NONE, 1'b0));
                q.push_back(mem_step(1'b0, ASEL_SP, S_PCLD | S_SPINC));
            end
            OP_LDX: begin
                q.push_back(fx_step(S_NONE, 1'b0));
                q.push_back(mem_step(1'b0, ASEL_REG, S_REG));
            end
            OP_STX: begin
                q.push_back(fx_step(S_NONE, 1'b0));
                q.push_back(mem_step(1'b1, ASEL_REG, S_NONE));
            end
            OP_PUSH: begin
                q.push_back(fx_step(S_SPDEC, 1'b0));
                q.push_back(mem_step(1'b1, ASEL_SP, S_NONE));
            end
            OP_POP: begin
                q.push_back(fx_step(S_NONE, 1'b0));
                q.push_back(mem_step(1'b0, ASEL_SP, S_REG | S_SPINC));
            end
            OP_HLT: q.push_back(h);
            default: ;
        endcase
    endtask

    // Expected outputs for this cycle; advances the model by one cycle.
    task automatic model(input bit ack, input bit cnd, output logic [13:0] e);
        step_t s;
        e = '0;
        e[B_FAULT] = m_fault;
        if (m_halt) begin
            e[B_HALT] = 1'b1;
            return;
        end
        if (q.size() == 0) begin
            s = mem_step(1'b0, ASEL_PC, S_IR | S_PCINC);
            s.fetch = 1'b1;
            q.push_back(s);
        end
        s = q.pop_front();
        if (s.hlt) begin
            e[B_HALT] = 1'b1;
            m_halt = 1'b1;
            q.delete();
            return;
        end
        if (!s.mem) begin
            e = e | s.fx;
            if (s.jmp && cnd) e[B_PCLD] = 1'b1;
            return;
        end
        e[B_REQ] = 1'b1;
        e[B_WE] = s.we;
        e[B_ASEL +: 2] = s.asel;
        if (ack) begin
            e = e | s.fx;
            m_wait = 0;
            if (s.fetch) begin
                pend_op = (prog.size() > 0) ? prog.pop_front() : rand_op();
                pend_v = 1'b1;
                expand(pend_op);
            end
        end else begin
            q.push_front(s);
            m_wait++;
            if (TO > 0 && m_wait == TO) begin
                m_fault = 1'b1;
                m_halt = 1'b1;
                m_wait = 0;
                q.delete();
            end
        end
    endtask

    task automatic cycle(input bit ack, input bit cnd);
        logic [13:0] obs, e;
        mem_ack = ack;
        cond_true = cnd;
        @(negedge clk);
        obs = obs_vec();
        model(ack, cnd, e);
        chk("cycle_outputs", {18'd0, obs}, {18'd0, e});
        cyc++;
        if (cyc < 64) lg[cyc] = obs;
        @(posedge clk);
        #1;
        if (pend_v) begin
            opcode = pend_op;
            pend_v = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ack = 1'b1;
            cond_true = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("reset_outputs", {18'd0, obs_vec()}, 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        q.delete();
        prog.delete();
        m_halt = 1'b0;
        m_fault = 1'b0;
        m_wait = 0;
        pend_v = 1'b0;
        cyc = 0;
    endtask

    function automatic int cnt(input int b, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(lg[i][b]);
        return n;
    endfunction

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        opcode = OP_NOP;
        cond_true = 1'b0;
        mem_ack = 1'b0;

        do_reset(2);
        prog.push_back(OP_NOP);
        cycle(1'b1, 1'b0);
        chk("first_req", {31'd0, lg[1][B_REQ]}, 32'd1);
        chk("first_asel", {30'd0, lg[1][B_ASEL +: 2]}, 32'd0);

        do_reset(2);
        prog.push_back(OP_MOV);
        repeat (4) cycle(1'b1, 1'b0);
        chk("mov_ir_we@1", {31'd0, lg[1][B_IR]}, 32'd1);
        chk("mov_reg_we@3", {31'd0, lg[3][B_REG]}, 32'd1);
        chk("mov_req@3", {31'd0, lg[3][B_REQ]}, 32'd0);
        chk("mov_req@4", {31'd0, lg[4][B_REQ]}, 32'd1);
        chk("mov_pc_inc_count", cnt(B_PCINC, 1, 3), 32'd1);

        do_reset(2);
        prog.push_back(OP_JMP);
        prog.push_back(OP_JMP);
        for (int c = 1; c <= 8; c++) cycle(1'b1, c > 4);
        chk("jmp0_imm_we@3", {31'd0, lg[3][B_IMM]}, 32'd1);
        chk("jmp0_pc_load@4", {31'd0, lg[4][B_PCLD]}, 32'd0);
        chk("jmp1_imm_we@7", {31'd0, lg[7][B_IMM]}, 32'd1);
        chk("jmp1_pc_load@8", {31'd0, lg[8][B_PCLD]}, 32'd1);

        do_reset(2);
        prog.push_back(OP_PUSH);
        prog.push_back(OP_POP);
        for (int c = 1; c <= 14; c++)
            cycle(!(c inside {4, 5, 6, 11, 12, 13}), 1'b0);
        chk("push_sp_dec_count", cnt(B_SPDEC, 1, 7), 32'd1);
        chk("push_sp_dec@3", {31'd0, lg[3][B_SPDEC]}, 32'd1);
        chk("push_we_cycles", cnt(B_WE, 1, 8), 32'd4);
        chk("push_asel@4", {30'd0, lg[4][B_ASEL +: 2]}, 32'd2);
        chk("pop_reg_we@13", {31'd0, lg[13][B_REG]}, 32'd0);
        chk("pop_reg_we@14", {31'd0, lg[14][B_REG]}, 32'd1);
        chk("pop_sp_inc@14", {31'd0, lg[14][B_SPINC]}, 32'd1);

        do_reset(2);
        prog.push_back(OP_CALL);
        prog.push_back(OP_RET);
        repeat (9) cycle(1'b1, 1'b0);
        chk("call_sp_dec@4", {31'd0, lg[4][B_SPDEC]}, 32'd1);
        chk("call_we@5", {31'd0, lg[5][B_WE]}, 32'd1);
        chk("call_asel@5", {30'd0, lg[5][B_ASEL +: 2]}, 32'd2);
        chk("call_pc_load@5", {31'd0, lg[5][B_PCLD]}, 32'd1);
        chk("ret_we@9", {31'd0, lg[9][B_WE]}, 32'd0);
        chk("ret_asel@9", {30'd0, lg[9][B_ASEL +: 2]}, 32'd2);
        chk("ret_pc_load@9", {31'd0, lg[9][B_PCLD]}, 32'd1);
        chk("ret_sp_inc@9", {31'd0, lg[9][B_SPINC]}, 32'd1);

        do_reset(2);
        prog.push_back(OP_HLT);
        repeat (22) cycle(1'b1, 1'b0);
        chk("hlt_halted@2", {31'd0, lg[2][B_HALT]}, 32'd0);
        chk("hlt_halted@3", {31'd0, lg[3][B_HALT]}, 32'd1);
        chk("hlt_req_count", cnt(B_REQ, 3, 22), 32'd0);

        do_reset(2);
        prog.push_back(OP_MOV);
        repeat (20) cycle(1'b0, 1'b0);
        chk("to_req@16", {31'd0, lg[16][B_REQ]}, 32'd1);
        chk("to_fault@16", {31'd0, lg[16][B_FAULT]}, 32'd0);
        chk("to_fault@17", {31'd0, lg[17][B_FAULT]}, 32'd1);
        chk("to_halted@17", {31'd0, lg[17][B_HALT]}, 32'd1);
        chk("to_req@17", {31'd0, lg[17][B_REQ]}, 32'd0);
        do_reset(1);
        cycle(1'b1, 1'b0);
        chk("to_fault_cleared", {31'd0, lg[1][B_FAULT]}, 32'd0);
        chk("to_halt_cleared", {31'd0, lg[1][B_HALT]}, 32'd0);

        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            if (m_halt || $urandom_range(0, 299) == 0)
                do_reset(int'($urandom_range(1, 2)));
            cycle($urandom_range(0, 99) < 65, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
